// File: rtl/store_byte_merge.sv
// Store path for a word-addressed data memory: word stores write directly,
// byte stores read-modify-write the containing word. Holds req_ready low while busy.
module store_byte_merge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_byte,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rdata_valid,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]       r_state;
  logic [WA_W-1:0]  r_addr;
  logic [1:0]       r_lane;
  logic [31:0]      r_data;
  logic             r_byte;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_rd_en;
  logic             r_wr_en;
  logic             r_done;
  logic             r_err;

  logic [1:0]       w_state_nxt;
  logic [WA_W-1:0]  w_addr_nxt;
  logic [1:0]       w_lane_nxt;
  logic [31:0]      w_data_nxt;
  logic             w_byte_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;
  logic [4:0]       w_shift;
  logic [31:0]      w_mask;
  logic [31:0]      w_merged;

  // Insert the latched low byte into the addressed little-endian lane
  always_comb begin
    w_shift  = {r_lane, 3'b000};
    w_mask   = 32'h0000_00FF << w_shift;
    w_merged = (mem_rdata & ~w_mask) | (32'(r_data[7:0]) << w_shift);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_lane_nxt  = r_lane;
    w_data_nxt  = r_data;
    w_byte_nxt  = r_byte;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_addr_nxt  = req_addr[ADDR_W-1:2];
          w_lane_nxt  = req_addr[1:0];
          w_data_nxt  = req_wdata;
          w_byte_nxt  = req_byte;
          w_cnt_nxt   = '0;
          w_state_nxt = req_byte ? S_READ : S_WRITE;
        end
      end
      S_READ: w_state_nxt = S_WAIT;
      S_WAIT: begin
        // A valid arriving on the last allowed cycle still wins over the timeout
        if (mem_rdata_valid) begin
          w_data_nxt  = w_merged;
          w_state_nxt = S_WRITE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they align with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_lane  <= '0;
      r_data  <= '0;
      r_byte  <= 1'b0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_lane  <= w_lane_nxt;
      r_data  <= w_data_nxt;
      r_byte  <= w_byte_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_rd_en <= (w_state_nxt == S_READ);
      r_wr_en <= (w_state_nxt == S_WRITE);
      r_done  <= (w_state_nxt == S_WRITE);
      r_err   <= w_err_nxt;
    end
  end

  assign req_ready = r_ready;
  assign mem_rd_en = r_rd_en;
  assign mem_wr_en = r_wr_en;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_data;

endmodule

// File: doc/store_byte_merge.md
Name: store_byte_merge

Overview:
- Store-side counterpart of the load byte-extension path in the MEM stage.
- Accepts word and byte stores from the pipeline against a word-addressed data memory.
- Word stores are written directly. Byte stores run a read-modify-write: read the word, insert the byte into its lane, write the merged word back.
- Holds the pipeline through `req_ready` while a store is in flight.

Parameters:
- `ADDR_W`, 32: byte address width.
- `TIMEOUT`, 16: maximum cycles spent in WAIT for `mem_rdata_valid` before the store is aborted; legal range 1..255.

Ports:
- `clk`  input  1  single clock, rising edge.
- `reset_n`  input  1  reset, asynchronous, active-low.
- `req_valid`  input  1  store request from the MEM stage.
- `req_ready`  output  1  block can accept a request this cycle.
- `req_addr`  input  `ADDR_W`  byte address.
- `req_wdata`  input  32  store data; a byte store uses bits [7:0] only.
- `req_byte`  input  1  1 = byte store, 0 = word store.
- `mem_addr`  output  `ADDR_W`-2  word address to data memory.
- `mem_rd_en`  output  1  memory read strobe.
- `mem_rdata`  input  32  memory read data.
- `mem_rdata_valid`  input  1  `mem_rdata` is valid this cycle.
- `mem_wr_en`  output  1  memory write strobe.
- `mem_wdata`  output  32  memory write data.
- `done`  output  1  one-cycle pulse: store committed.
- `err`  output  1  one-cycle pulse: byte store aborted on timeout.

Behaviour:
- Reset asserted (async): state = IDLE; all latched registers = 0.
  - Outputs during and after reset: `req_ready`=1; `mem_rd_en`, `mem_wr_en`, `done`, `err` = 0; `mem_addr`, `mem_wdata` = 0.
  - Reset mid-operation aborts the store. No write is issued.
- All outputs are Moore-style: decoded from the state and latched registers, never combinational from inputs.
- Accept: handshake is `req_valid & req_ready` at a rising edge. On accept the block latches:
  - word address = `req_addr[ADDR_W-1:2]`
  - lane = `req_addr[1:0]`
  - `req_wdata`
  - `req_byte`
- Lane mapping is little-endian: lane 0 = bits [7:0], lane 1 = [15:8], lane 2 = [23:16], lane 3 = [31:24].
- FSM states:
  - IDLE:
    - `req_ready`=1.
    - On accept: word store → WRITE; byte store → READ; wait counter cleared.
  - READ:
    - `mem_rd_en`=1, `mem_addr` = latched word address, for exactly one cycle.
    - → WAIT.
  - WAIT:
    - `mem_addr` held.
    - Counter increments each cycle `mem_rdata_valid`=0.
    - If `mem_rdata_valid`=1: latch the merged word → WRITE. Merged word = `mem_rdata` with the selected lane replaced by latched data [7:0]; other lanes unchanged.
    - Else if counter = `TIMEOUT`-1: `err` pulse on the next cycle, → IDLE, no write.
    - If `mem_rdata_valid` arrives in the same cycle the counter expires, valid wins: normal merge, no `err`.
  - WRITE:
    - `mem_wr_en`=1 and `done`=1 for one cycle.
    - `mem_addr` = latched word address.
    - `mem_wdata` = latched data (word store) or merged word (byte store).
    - → IDLE.
- `req_ready`=0 in READ, WAIT and WRITE. New requests are not accepted until the state is IDLE again.
- `mem_rdata_valid` outside WAIT is ignored.
- `err` is registered: it is high in the first IDLE cycle after the abort, and `req_ready` is also 1 in that cycle.
- Latency, accept at edge N:
  - Word store: WRITE in cycle N+1; ready again at N+2.
  - Byte store: READ in N+1; WAIT from N+2. If valid is seen in cycle M, WRITE is in M+1 and ready again at M+2.
  - Minimum byte-store occupancy is 4 cycles (READ, WAIT, WRITE, back to IDLE).
- `req_addr[1:0]` is ignored for word stores; no misalignment check.
- Width rules: `mem_addr` width = `ADDR_W`-2. Counter width holds values up to `TIMEOUT`.

Test Plan:
- Reset values: hold `reset_n`=0 for 3 cycles, then release → `req_ready`=1; `mem_rd_en`=`mem_wr_en`=`done`=`err`=0; `mem_addr`=0; `mem_wdata`=0.
- Word store: `req_addr`=0x0000_0107, `req_wdata`=0xDEAD_BEEF, `req_byte`=0 → next cycle `mem_wr_en`=1, `mem_addr`=0x41, `mem_wdata`=0xDEADBEEF, `done`=1; `req_ready`=1 the cycle after.
- Byte store, all lanes: memory word 0x1122_3344, `req_wdata`=0x0000_00AB, lanes 0..3 → `mem_wdata` = 0x112233AB, 0x1122AB44, 0x11AB3344, 0xAB223344; `mem_rd_en` pulses exactly once per store.
- Variable read latency: `mem_rdata_valid` at 0, 1 and 5 cycles into WAIT, plus a spurious valid while in IDLE → write follows valid by one cycle; spurious valid causes no write; `req_valid` held high throughout is accepted only when `req_ready`=1.
- Timeout with `TIMEOUT`=4:
  - Never assert valid → `err` pulse, no `mem_wr_en`, back to IDLE.
  - Assert valid in the 4th WAIT cycle → normal write, no `err`.
- Reset mid-operation: drop `reset_n` during WAIT → immediate IDLE outputs; no `mem_wr_en` after release; the next word store completes normally.
